mac_job_sched: RTL and testbench
================================

# mac_job_sched

Round-robin job scheduler that shares one signed 8×8 multiply-accumulate datapath between two requesters. Each requester asks for a dot-product job of programmable length. The scheduler grants one job at a time and clears the accumulator at grant. It streams that requester's operand pairs through a 2-stage MAC and returns the ACC_W-bit signed sum, tagged with the requester ID, on a valid/ready result port. The block sits between the vector-producing front ends and the result sink. It is the single owner of the MAC resource.

## Interface
Parameters:
- LEN_W, 8: job length counter width; maximum length is 2^LEN_W−1.
- ACC_W, 19: accumulator and result width, two's complement.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- s_start, in, 2: per-requester job request; held high until the matching s_grant.
- s_len, in, 2×LEN_W: per-requester job length; slice i = [i×LEN_W +: LEN_W]; sampled on grant.
- s_grant, out, 2: one-cycle pulse on the cycle a job is accepted.
- s_valid, in, 2: per-requester operand pair valid.
- s_a, in, 16: per-requester signed 8-bit operand A; slice i = [8i +: 8].
- s_b, in, 16: per-requester signed 8-bit operand B; same slicing as s_a.
- s_ready, out, 2: per-requester operand ready; only the owner's bit can be high.
- res_valid, out, 1: result valid.
- res_ready, in, 1: result consumed.
- res_data, out, ACC_W: signed dot-product result.
- res_id, out, 1: requester that owns the result.
- res_ovf, out, 1: sticky signed overflow seen during the job.
- busy, out, 1: high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE → RUN (len > 0) or DONE (len = 0) when any s_start is high.
  - RUN → DRAIN when the last element is accepted.
  - DRAIN → DONE after one cycle.
  - DONE → IDLE on res_valid & res_ready.
- Arbitration:
  - Round-robin pointer prio resets to 0.
  - If both requesters have s_start high, requester prio wins; otherwise the single requester wins.
  - After the result handshake, prio ← !owner.
- Grant: on the IDLE exit edge the block:
  - registers the owner and s_len[owner] into the remaining-count register;
  - clears the accumulator and res_ovf;
  - sets s_grant[owner] to 1 for the following cycle.
- RUN:
  - s_ready[owner] = 1.
  - Each s_valid & s_ready handshake loads the operand registers and decrements the count.
  - Requester input is ignored while the owner is busy, including a new s_start from the owner.
- MAC datapath:
  - Stage 1: operand registers.
  - Stage 2: 16-bit signed product, sign-extended to ACC_W, added into the accumulator.
  - The accumulator adds only when the stage-1 valid bit is set.
- Overflow:
  - res_ovf is set when the add result sign differs from the sign of both operands while those signs are equal.
  - Default: the sum wraps modulo 2^ACC_W.
- DONE:
  - res_valid = 1; res_data, res_id and res_ovf are held stable until res_ready.
  - A len = 0 job returns res_data = 0.
- Reset values of all outputs are 0. rst in any state aborts the job; no result is emitted and prio returns to 0.

## Timing
- s_start high in an IDLE cycle t → s_grant pulse and first possible s_ready in cycle t+1.
- Accept rate is one element per cycle with no bubbles while s_valid is held.
- Last element accepted at edge E → accumulate at edge E+1 → res_valid high from cycle E+1. Latency is 2 cycles, matching the existing MAC.
- len = 0: res_valid in cycle t+1, the same cycle as s_grant.
- Back-to-back jobs: after the result handshake edge the FSM is in IDLE for one cycle; the next grant follows one cycle later.
- s_ready drops in the cycle after the last handshake; there is no extra acceptance.

## Configuration
- MAC_SAT_EN defined:
  - The accumulator saturates to +2^(ACC_W−1)−1 or −2^(ACC_W−1) on overflow, and later additions continue from the clamped value.
  - res_ovf behaves as in the default build.
- MAC_SAT_EN undefined: wrap-around arithmetic as described in Operation.

## Structure
- Shared package mac_sched_pkg:
  - FSM state encoding (IDLE, RUN, DRAIN, DONE);
  - default LEN_W and ACC_W;
  - number of requesters (2).
- Sub-module mac_acc_core holds the 2-stage signed MAC with clear, in_valid and the saturation option. mac_job_sched contains the arbiter, FSM, counter and result register.

## Test plan
- Requester 0, len = 3, pairs (2,3), (−4,5), (7,−1) → res_data = −21, res_id = 0, res_ovf = 0; res_valid 2 cycles after the third handshake.
- Both requesters assert s_start in the same cycle after reset → requester 0 is granted first and requester 1 immediately after the result; a third simultaneous request then goes to requester 0.
- Requester 1, len = 16, all pairs (−128,−128):
  - default build → res_data = −262144, res_ovf = 1;
  - MAC_SAT_EN build → res_data = 262143, res_ovf = 1.
- Requester 0, len = 15, all pairs (−128,−128) → res_data = 245760, res_ovf = 0.
- len = 0 → grant and res_valid in the same cycle, res_data = 0; with res_ready held low for 5 cycles, the outputs stay stable.
- rst asserted mid-RUN after 2 of 4 elements → all outputs 0 next cycle; the next job's result excludes the aborted partial sum.

Source files
------------

// File: rtl/mac_job_sched_pkg.sv
// mac_sched_pkg: shared definitions for the MAC job scheduler slice.
//   - state_t   : scheduler FSM encoding (IDLE, RUN, DRAIN, DONE)
//   - DEF_LEN_W : default job length counter width
//   - DEF_ACC_W : default accumulator / result width
//   - NUM_REQ   : number of requesters sharing the MAC
//   - OP_W      : signed operand width
//   - req_onehot: requester id -> one-hot request vector
// Optional feature macro used by the slice: MAC_SAT_EN (saturating accumulate).
package mac_sched_pkg;

    localparam int unsigned DEF_LEN_W = 8;
    localparam int unsigned DEF_ACC_W = 19;
    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned OP_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/mac_job_sched_if.sv
// mac_job_sched_if: requester and result-sink signals of mac_job_sched.
//   master modport : requester front ends + result sink (drive requests/operands,
//                    consume results)
//   slave modport  : the scheduler itself
// Signals:
//   s_start[NUM_REQ]      job request per requester, held until s_grant
//   s_len[NUM_REQ*LEN_W]  job length per requester, slice i = [i*LEN_W +: LEN_W]
//   s_grant[NUM_REQ]      one-cycle grant pulse
//   s_valid/s_ready       per-requester operand handshake
//   s_a/s_b[NUM_REQ*8]    signed operands, slice i = [8i +: 8]
//   res_valid/res_ready   result handshake
//   res_data[ACC_W]       signed dot-product, res_id owner, res_ovf sticky overflow
interface mac_job_sched_if #(
    parameter int unsigned LEN_W = mac_sched_pkg::DEF_LEN_W,
    parameter int unsigned ACC_W = mac_sched_pkg::DEF_ACC_W
);
    import mac_sched_pkg::*;

    logic [NUM_REQ-1:0]       s_start;
    logic [NUM_REQ*LEN_W-1:0] s_len;
    logic [NUM_REQ-1:0]       s_grant;
    logic [NUM_REQ-1:0]       s_valid;
    logic [NUM_REQ*OP_W-1:0]  s_a;
    logic [NUM_REQ*OP_W-1:0]  s_b;
    logic [NUM_REQ-1:0]       s_ready;
    logic                     res_valid;
    logic                     res_ready;
    logic [ACC_W-1:0]         res_data;
    logic                     res_id;
    logic                     res_ovf;

    modport master (
        output s_start, s_len, s_valid, s_a, s_b, res_ready,
        input  s_grant, s_ready, res_valid, res_data, res_id, res_ovf
    );

    modport slave (
        input  s_start, s_len, s_valid, s_a, s_b, res_ready,
        output s_grant, s_ready, res_valid, res_data, res_id, res_ovf
    );

endinterface

// File: rtl/mac_job_sched_acc.sv
// mac_acc_core: 2-stage signed 8x8 multiply-accumulate.
//   Stage 1 registers the operand pair when in_valid is high.
//   Stage 2 adds the sign-extended 16-bit product into acc when the stage-1
//   valid bit is set, and latches a sticky signed-overflow flag.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         synchronous clear of pipeline, accumulator and overflow flag
//   in_valid      operand pair valid
//   in_a, in_b    signed 8-bit operands
//   acc           ACC_W-bit signed accumulator
//   ovf           sticky overflow since the last clear
// Config macro: MAC_SAT_EN -> clamp to the signed range on overflow instead of
// wrapping modulo 2^ACC_W.
module mac_acc_core #(
    parameter int unsigned ACC_W = mac_sched_pkg::DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [7:0]       in_a,
    input  logic signed [7:0]       in_b,
    output logic signed [ACC_W-1:0] acc,
    output logic                    ovf
);
    logic signed [7:0]       a_q;
    logic signed [7:0]       b_q;
    logic                    v_q;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_next;
    logic                    add_ovf;

    always_comb begin
        prod     = a_q * b_q;
        prod_ext = {{(ACC_W-16){prod[15]}}, prod};
        sum      = acc + prod_ext;
        // Overflow: operands agree in sign but the sum does not.
        add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef MAC_SAT_EN
        if (add_ovf) begin
            acc_next = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_next = sum;
        end
`else
        acc_next = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            v_q <= in_valid;
            if (in_valid) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            if (v_q) begin
                acc <= acc_next;
                ovf <= ovf | add_ovf;
            end
        end
    end

endmodule

// File: rtl/mac_job_sched.sv
// mac_job_sched: round-robin job scheduler sharing one 2-stage signed MAC
// between two requesters.
//   A requester raises s_start with a job length; the scheduler grants one job
//   at a time (ties broken by the round-robin pointer), clears the accumulator,
//   streams the owner's operand pairs into mac_acc_core and returns the sum,
//   owner id and sticky overflow on the res_* valid/ready port.
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts any job)
//   bus        mac_job_sched_if.slave (request, operand and result signals)
//   busy       high whenever the FSM is not IDLE
// Config macro: MAC_SAT_EN (forwarded to mac_acc_core, saturating accumulate).
module mac_job_sched #(
    parameter int unsigned LEN_W = mac_sched_pkg::DEF_LEN_W,
    parameter int unsigned ACC_W = mac_sched_pkg::DEF_ACC_W
) (
    input  logic            clk,
    input  logic            rst,
    mac_job_sched_if.slave  bus,
    output logic            busy
);
    import mac_sched_pkg::*;

    state_t                  state_q;
    state_t                  state_d;
    logic                    owner_q;
    logic                    prio_q;
    logic [LEN_W-1:0]        cnt_q;
    logic [NUM_REQ-1:0]      grant_q;

    logic                    any_start;
    logic                    winner;
    logic [LEN_W-1:0]        win_len;
    logic                    grant_fire;
    logic                    accept;
    logic                    res_fire;
    logic [NUM_REQ-1:0]      ready;
    logic signed [OP_W-1:0]  op_a;
    logic signed [OP_W-1:0]  op_b;
    logic signed [ACC_W-1:0] acc;
    logic                    acc_ovf;

    // Arbitration: pointer wins a tie, otherwise the lone requester wins.
    always_comb begin
        any_start = |bus.s_start;
        if (&bus.s_start) begin
            winner = prio_q;
        end else begin
            winner = bus.s_start[1];
        end
        win_len = winner ? bus.s_len[LEN_W +: LEN_W] : bus.s_len[0 +: LEN_W];
    end

    always_comb begin
        ready = '0;
        if (state_q == RUN) begin
            ready = req_onehot(owner_q);
        end
        op_a       = owner_q ? bus.s_a[OP_W +: OP_W] : bus.s_a[0 +: OP_W];
        op_b       = owner_q ? bus.s_b[OP_W +: OP_W] : bus.s_b[0 +: OP_W];
        grant_fire = (state_q == IDLE) && any_start;
        accept     = (state_q == RUN) && bus.s_valid[owner_q];
        res_fire   = (state_q == DONE) && bus.res_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_start) begin
                    state_d = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && (cnt_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            // One cycle for the last pair to move from stage 1 into acc.
            DRAIN: state_d = DONE;
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= '0;
            if (grant_fire) begin
                owner_q <= winner;
                cnt_q   <= win_len;
                grant_q <= req_onehot(winner);
            end
            if (accept) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end
            if (res_fire) begin
                prio_q <= !owner_q;
            end
        end
    end

    mac_acc_core #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear    (grant_fire),
        .in_valid (accept),
        .in_a     (op_a),
        .in_b     (op_b),
        .acc      (acc),
        .ovf      (acc_ovf)
    );

    // acc does not move in DONE, so the result needs no separate holding register.
    always_comb begin
        bus.s_grant   = grant_q;
        bus.s_ready   = ready;
        bus.res_valid = (state_q == DONE);
        bus.res_data  = acc;
        bus.res_id    = owner_q;
        bus.res_ovf   = acc_ovf;
        busy          = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mac_job_sched.sv
module tb_mac_job_sched;

    localparam int unsigned LEN_W = 8;
    localparam int unsigned ACC_W = 19;

    logic clk;
    logic rst;
    logic busy;

    int n_checks;
    int n_fail;

    logic signed [7:0] va [16];
    logic signed [7:0] vb [16];

    mac_job_sched_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

    mac_job_sched #(
        .LEN_W (LEN_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic consume;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    // Runs one job for requester id using va/vb. Returns with the result
    // pending (res_valid high). lat counts edges from the last handshake edge
    // (inclusive) to res_valid; for len 0 it counts edges after the grant.
    task automatic do_job(input int id, input int len, output int lat,
                          output bit to, output bit rdy_after);
        int k;
        to = 1'b0;
        lat = 0;
        rdy_after = 1'b0;
        bus.s_len[id*8 +: 8] = 8'(len);
        bus.s_start[id] = 1'b1;
        k = 0;
        tick();
        while (!bus.s_grant[id] && k < 20) begin
            tick();
            k++;
        end
        if (!bus.s_grant[id]) to = 1'b1;
        bus.s_start[id] = 1'b0;
        for (int i = 0; i < len; i++) begin
            bus.s_valid[id] = 1'b1;
            bus.s_a[id*8 +: 8] = va[i];
            bus.s_b[id*8 +: 8] = vb[i];
            k = 0;
            while (!bus.s_ready[id] && k < 20) begin
                tick();
                k++;
            end
            if (!bus.s_ready[id]) to = 1'b1;
            tick();
        end
        bus.s_valid[id] = 1'b0;
        if (len > 0) begin
            rdy_after = bus.s_ready[id];
            lat = 1;
        end
        k = 0;
        while (!bus.res_valid && k < 40) begin
            tick();
            lat++;
            k++;
        end
        if (!bus.res_valid) to = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.s_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got=%b exp=00", bus.s_grant); end
        n_checks++; if (bus.s_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", bus.s_ready); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
        n_checks++; if (bus.res_data !== '0) begin n_fail++; $display("FAIL reset_res_data got=%h exp=0", bus.res_data); end
        n_checks++; if (bus.res_id !== 1'b0) begin n_fail++; $display("FAIL reset_res_id got=%b exp=0", bus.res_id); end
        n_checks++; if (bus.res_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_res_ovf got=%b exp=0", bus.res_ovf); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int lat;
        bit to;
        bit ra;
        va[0] = 8'sd2;  vb[0] = 8'sd3;
        va[1] = -8'sd4; vb[1] = 8'sd5;
        va[2] = 8'sd7;  vb[2] = -8'sd1;
        do_job(0, 3, lat, to, ra);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got=%b exp=0", to); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL basic_latency got=%0d exp=2", lat); end
        n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL basic_ready_after_last got=%b exp=0", ra); end
        n_checks++; if (bus.res_data !== ACC_W'(-21)) begin n_fail++; $display("FAIL basic_data got=%h exp=%h", bus.res_data, ACC_W'(-21)); end
        n_checks++; if (bus.res_id !== 1'b0) begin n_fail++; $display("FAIL basic_id got=%b exp=0", bus.res_id); end
        n_checks++; if (bus.res_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", bus.res_ovf); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy); end
        consume();
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_res_valid_after got=%b exp=0", bus.res_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after got=%b exp=0", busy); end
    endtask

    // prio is 1 on entry (requester 0 finished last); rst must return it to 0.
    task automatic test_reset_abort;
        int k;
        bus.s_len[15:8] = 8'd4;
        bus.s_start[1] = 1'b1;
        tick();
        n_checks++; if (bus.s_grant !== 2'b10) begin n_fail++; $display("FAIL abort_grant got=%b exp=10", bus.s_grant); end
        bus.s_start[1] = 1'b0;
        bus.s_valid[1] = 1'b1;
        bus.s_a[15:8] = 8'sd10; bus.s_b[15:8] = 8'sd1;
        tick();
        bus.s_a[15:8] = 8'sd20;
        tick();
        rst = 1'b1;
        bus.s_a[15:8] = 8'sd30;
        tick();
        n_checks++; if (bus.s_grant !== 2'b00) begin n_fail++; $display("FAIL abort_rst_grant got=%b exp=00", bus.s_grant); end
        n_checks++; if (bus.s_ready !== 2'b00) begin n_fail++; $display("FAIL abort_rst_ready got=%b exp=00", bus.s_ready); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rst_res_valid got=%b exp=0", bus.res_valid); end
        n_checks++; if (bus.res_data !== '0) begin n_fail++; $display("FAIL abort_rst_res_data got=%h exp=0", bus.res_data); end
        n_checks++; if (bus.res_id !== 1'b0) begin n_fail++; $display("FAIL abort_rst_res_id got=%b exp=0", bus.res_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_rst_busy got=%b exp=0", busy); end
        rst = 1'b0;
        bus.s_valid = 2'b00;
        bus.s_len = {8'd1, 8'd1};
        bus.s_start = 2'b11;
        tick();
        n_checks++; if (bus.s_grant !== 2'b01) begin n_fail++; $display("FAIL abort_prio_reset got=%b exp=01", bus.s_grant); end
        bus.s_start = 2'b00;
        bus.s_valid[0] = 1'b1;
        bus.s_a[7:0] = 8'sd5; bus.s_b[7:0] = 8'sd5;
        tick();
        bus.s_valid[0] = 1'b0;
        k = 0;
        while (!bus.res_valid && k < 20) begin tick(); k++; end
        n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL abort_next_valid got=%b exp=1", bus.res_valid); end
        n_checks++; if (bus.res_data !== ACC_W'(25)) begin n_fail++; $display("FAIL abort_next_data got=%h exp=%h", bus.res_data, ACC_W'(25)); end
        consume();
    endtask

    task automatic test_overflow_wrap;
        int lat;
        bit to;
        bit ra;
        logic [ACC_W-1:0] exp_d;
        for (int i = 0; i < 16; i++) begin
            va[i] = -8'sd128;
            vb[i] = -8'sd128;
        end
`ifdef MAC_SAT_EN
        exp_d = ACC_W'(262143);
`else
        exp_d = ACC_W'(-262144);
`endif
        do_job(1, 16, lat, to, ra);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL ovf16_timeout got=%b exp=0", to); end
        n_checks++; if (bus.res_data !== exp_d) begin n_fail++; $display("FAIL ovf16_data got=%h exp=%h", bus.res_data, exp_d); end
        n_checks++; if (bus.res_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf16_flag got=%b exp=1", bus.res_ovf); end
        n_checks++; if (bus.res_id !== 1'b1) begin n_fail++; $display("FAIL ovf16_id got=%b exp=1", bus.res_id); end
        consume();
    endtask

    task automatic test_no_overflow;
        int lat;
        bit to;
        bit ra;
        do_job(0, 15, lat, to, ra);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL len15_timeout got=%b exp=0", to); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL len15_latency got=%0d exp=2", lat); end
        n_checks++; if (bus.res_data !== ACC_W'(245760)) begin n_fail++; $display("FAIL len15_data got=%h exp=%h", bus.res_data, ACC_W'(245760)); end
        n_checks++; if (bus.res_ovf !== 1'b0) begin n_fail++; $display("FAIL len15_ovf got=%b exp=0", bus.res_ovf); end
        n_checks++; if (bus.res_id !== 1'b0) begin n_fail++; $display("FAIL len15_id got=%b exp=0", bus.res_id); end
        consume();
    endtask

    task automatic test_len0;
        int lat;
        bit to;
        bit ra;
        do_job(1, 0, lat, to, ra);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL len0_timeout got=%b exp=0", to); end
        n_checks++; if (lat != 0) begin n_fail++; $display("FAIL len0_latency got=%0d exp=0", lat); end
        n_checks++; if (bus.s_grant !== 2'b10) begin n_fail++; $display("FAIL len0_grant_same_cycle got=%b exp=10", bus.s_grant); end
        // Requests and operands arriving during DONE must be ignored.
        bus.s_start[0] = 1'b1;
        bus.s_len[7:0] = 8'd2;
        bus.s_valid = 2'b11;
        bus.s_a = 16'h7F7F;
        bus.s_b = 16'h7F7F;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL len0_hold_valid cyc=%0d got=%b exp=1", c, bus.res_valid); end
            n_checks++; if (bus.res_data !== '0) begin n_fail++; $display("FAIL len0_hold_data cyc=%0d got=%h exp=0", c, bus.res_data); end
            n_checks++; if (bus.res_id !== 1'b1) begin n_fail++; $display("FAIL len0_hold_id cyc=%0d got=%b exp=1", c, bus.res_id); end
            n_checks++; if (bus.res_ovf !== 1'b0) begin n_fail++; $display("FAIL len0_hold_ovf cyc=%0d got=%b exp=0", c, bus.res_ovf); end
            n_checks++; if (bus.s_grant !== 2'b00) begin n_fail++; $display("FAIL len0_hold_grant cyc=%0d got=%b exp=00", c, bus.s_grant); end
            n_checks++; if (bus.s_ready !== 2'b00) begin n_fail++; $display("FAIL len0_hold_ready cyc=%0d got=%b exp=00", c, bus.s_ready); end
        end
        bus.s_start = 2'b00;
        bus.s_valid = 2'b00;
        consume();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        int k;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.s_len = {8'd1, 8'd1};
        bus.s_start = 2'b11;
        tick();
        n_checks++; if (bus.s_grant !== 2'b01) begin n_fail++; $display("FAIL b2b_first_grant got=%b exp=01", bus.s_grant); end
        bus.s_start[0] = 1'b0;
        bus.s_valid = 2'b11;
        bus.s_a = {-8'sd5, 8'sd3};
        bus.s_b = {8'sd6, 8'sd4};
        n_checks++; if (bus.s_ready !== 2'b01) begin n_fail++; $display("FAIL b2b_owner_ready got=%b exp=01", bus.s_ready); end
        tick();
        bus.s_valid[0] = 1'b0;
        k = 0;
        while (!bus.res_valid && k < 20) begin tick(); k++; end
        n_checks++; if (bus.res_data !== ACC_W'(12)) begin n_fail++; $display("FAIL b2b_r0_data got=%h exp=%h", bus.res_data, ACC_W'(12)); end
        n_checks++; if (bus.res_id !== 1'b0) begin n_fail++; $display("FAIL b2b_r0_id got=%b exp=0", bus.res_id); end
        consume();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_idle got=%b exp=0", busy); end
        n_checks++; if (bus.s_grant !== 2'b00) begin n_fail++; $display("FAIL b2b_gap_grant got=%b exp=00", bus.s_grant); end
        tick();
        n_checks++; if (bus.s_grant !== 2'b10) begin n_fail++; $display("FAIL b2b_second_grant got=%b exp=10", bus.s_grant); end
        bus.s_start[1] = 1'b0;
        tick();
        bus.s_valid[1] = 1'b0;
        k = 0;
        while (!bus.res_valid && k < 20) begin tick(); k++; end
        n_checks++; if (bus.res_data !== ACC_W'(-30)) begin n_fail++; $display("FAIL b2b_r1_data got=%h exp=%h", bus.res_data, ACC_W'(-30)); end
        n_checks++; if (bus.res_id !== 1'b1) begin n_fail++; $display("FAIL b2b_r1_id got=%b exp=1", bus.res_id); end
        bus.s_start = 2'b11;
        consume();
        tick();
        n_checks++; if (bus.s_grant !== 2'b01) begin n_fail++; $display("FAIL b2b_third_grant got=%b exp=01", bus.s_grant); end
        bus.s_start = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.s_start = '0;
        bus.s_len = '0;
        bus.s_valid = '0;
        bus.s_a = '0;
        bus.s_b = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_reset_abort();
        test_overflow_wrap();
        test_no_overflow();
        test_len0();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
